rom_port_arbiter: RTL and testbench



---
 rtl/rom_port_arbiter_pkg.sv | 19 +
 rtl/rom_arb_starve.sv | 33 +++
 rtl/rom_port_arbiter.sv | 179 +++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// Shared types and defaults for the ROM0 port arbiter (CPU vs PI bus).
package rom_port_arbiter_pkg;

  localparam int ARB_AW          = 23;
  localparam int ARB_DW          = 16;
  localparam int ARB_PI_WAIT_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CPU_BUSY = 2'd1,
    ST_PI_BUSY  = 2'd2
  } arb_state_t;

  // Width of a counter that must be able to hold max_val itself.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rom_arb_starve.sv
// Saturating wait counter: counts cycles a PI request has been left waiting,
// sticks at MAX, and clears when PI is granted.
module rom_arb_starve
  import rom_port_arbiter_pkg::*;
#(
  parameter int MAX = ARB_PI_WAIT_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_max
);

  localparam int CW = cnt_width(MAX);
  localparam logic [CW-1:0] MAX_C = CW'(MAX);

  logic [CW-1:0] cnt_q;

  assign at_max = (cnt_q == MAX_C);

  // Clear wins over increment so a grant always leaves the counter at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && !at_max) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/rom_port_arbiter.sv
// ROM0 port arbiter: shares one memory port between 68k cart-bus reads and
// PI-bus (USB) accesses. CPU has priority; the starvation guard forces a PI
// grant once a PI request has waited PI_WAIT_MAX cycles.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_IDLE     | no access in flight, arbitrate this cycle
//   ST_CPU_BUSY | CPU read in flight, waiting for mem_ack
//   ST_PI_BUSY  | PI read/write in flight, waiting for mem_ack
module rom_port_arbiter
  import rom_port_arbiter_pkg::*;
#(
  parameter int AW          = ARB_AW,
  parameter int DW          = ARB_DW,
  parameter int PI_WAIT_MAX = ARB_PI_WAIT_MAX
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_act,
  input  logic [AW-1:0] cpu_addr,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_rdy,
  input  logic          pi_req,
  input  logic          pi_we,
  input  logic [AW-1:0] pi_addr,
  input  logic [DW-1:0] pi_wdat,
  output logic [DW-1:0] pi_rdat,
  output logic          pi_ack,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_di,
  input  logic [DW-1:0] mem_do,
  input  logic          mem_ack
);

  arb_state_t state_q, state_d;

  logic cpu_act_d;
  logic cpu_pend_q, cpu_pend_d;
  logic cpu_new, cpu_want;
  logic pi_starved;
  logic grant_cpu, grant_pi;
  logic starve_max;
  logic starve_inc;

  logic          mem_req_d;
  logic          mem_we_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_di_d;
  logic [DW-1:0] cpu_dout_d;
  logic          cpu_rdy_d;
  logic [DW-1:0] pi_rdat_d;
  logic          pi_ack_d;

  assign cpu_new    = cpu_act && !cpu_act_d;
  assign cpu_want   = cpu_new || cpu_pend_q;
  assign pi_starved = pi_req && starve_max;
  assign starve_inc = pi_req && (state_q != ST_PI_BUSY);

  rom_arb_starve #(
    .MAX (PI_WAIT_MAX)
  ) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (starve_inc),
    .clr    (grant_pi),
    .at_max (starve_max)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and grant decision; PI is not re-granted on its own ack cycle.
  always_comb begin
    state_d   = state_q;
    grant_cpu = 1'b0;
    grant_pi  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pi_starved) begin
          grant_pi = 1'b1;
          state_d  = ST_PI_BUSY;
        end else if (cpu_want) begin
          grant_cpu = 1'b1;
          state_d   = ST_CPU_BUSY;
        end else if (pi_req && !pi_ack) begin
          grant_pi = 1'b1;
          state_d  = ST_PI_BUSY;
        end
      end
      ST_CPU_BUSY, ST_PI_BUSY: begin
        if (mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the pending-CPU flag.
  always_comb begin
    mem_req_d  = mem_req;
    mem_we_d   = mem_we;
    mem_addr_d = mem_addr;
    mem_di_d   = mem_di;
    cpu_dout_d = cpu_dout;
    cpu_rdy_d  = cpu_rdy;
    pi_rdat_d  = pi_rdat;
    pi_ack_d   = 1'b0;
    cpu_pend_d = cpu_pend_q;

    if (grant_cpu) begin
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = cpu_addr;
    end else if (grant_pi) begin
      mem_req_d  = 1'b1;
      mem_we_d   = pi_we;
      mem_addr_d = pi_addr;
      mem_di_d   = pi_wdat;
    end

    // An in-flight access always runs to completion; late CPU data is dropped.
    if (state_q == ST_CPU_BUSY && mem_ack) begin
      mem_req_d = 1'b0;
      if (cpu_act) begin
        cpu_dout_d = mem_do;
        cpu_rdy_d  = 1'b1;
      end
    end else if (!cpu_act) begin
      cpu_rdy_d = 1'b0;
    end

    if (state_q == ST_PI_BUSY && mem_ack) begin
      mem_req_d = 1'b0;
      pi_ack_d  = 1'b1;
      if (!mem_we) pi_rdat_d = mem_do;
    end

    if (grant_cpu || !cpu_act) begin
      cpu_pend_d = 1'b0;
    end else if (cpu_new) begin
      cpu_pend_d = 1'b1;
    end
  end

  // Output and bookkeeping registers; reset drops mem_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_act_d  <= 1'b0;
      cpu_pend_q <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_di     <= '0;
      cpu_dout   <= '0;
      cpu_rdy    <= 1'b0;
      pi_rdat    <= '0;
      pi_ack     <= 1'b0;
    end else begin
      cpu_act_d  <= cpu_act;
      cpu_pend_q <= cpu_pend_d;
      mem_req    <= mem_req_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_di     <= mem_di_d;
      cpu_dout   <= cpu_dout_d;
      cpu_rdy    <= cpu_rdy_d;
      pi_rdat    <= pi_rdat_d;
      pi_ack     <= pi_ack_d;
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench for rom_port_arbiter: CPU read, PI write/read, priority,
// starvation guard, aborted CPU cycle and reset during a PI access.
module tb_rom_port_arbiter;
  import rom_port_arbiter_pkg::*;

  logic          clk;
  logic          rst_n;
  logic          cpu_act;
  logic [22:0]   cpu_addr;
  logic [15:0]   cpu_dout;
  logic          cpu_rdy;
  logic          pi_req;
  logic          pi_we;
  logic [22:0]   pi_addr;
  logic [15:0]   pi_wdat;
  logic [15:0]   pi_rdat;
  logic          pi_ack;
  logic          mem_req;
  logic          mem_we;
  logic [22:0]   mem_addr;
  logic [15:0]   mem_di;
  logic [15:0]   mem_do;
  logic          mem_ack;

  int checks   = 0;
  int failures = 0;

  rom_port_arbiter dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_act  (cpu_act),
    .cpu_addr (cpu_addr),
    .cpu_dout (cpu_dout),
    .cpu_rdy  (cpu_rdy),
    .pi_req   (pi_req),
    .pi_we    (pi_we),
    .pi_addr  (pi_addr),
    .pi_wdat  (pi_wdat),
    .pi_rdat  (pi_rdat),
    .pi_ack   (pi_ack),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_di   (mem_di),
    .mem_do   (mem_do),
    .mem_ack  (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n    = 1'b0;
    cpu_act  = 1'b0;
    cpu_addr = '0;
    pi_req   = 1'b0;
    pi_we    = 1'b0;
    pi_addr  = '0;
    pi_wdat  = '0;
    mem_do   = '0;
    mem_ack  = 1'b0;

    // Reset values
    tick();
    tick();
    chk("rst_mem_req", 32'(mem_req), 32'h0);
    chk("rst_outs", 32'({cpu_rdy, pi_ack, mem_we}), 32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_cpu_dout", 32'(cpu_dout), 32'h0);
    chk("rst_pi_rdat", 32'(pi_rdat), 32'h0);
    chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

    // 1: CPU read, ack three cycles after mem_req
    cpu_act  = 1'b1;
    cpu_addr = 23'h001234;
    tick();
    chk("t1_mem_req", 32'(mem_req), 32'h1);
    chk("t1_mem_addr", 32'(mem_addr), 32'h001234);
    chk("t1_mem_we", 32'(mem_we), 32'h0);
    tick();
    tick();
    chk("t1_req_held", 32'(mem_req), 32'h1);
    mem_ack = 1'b1;
    mem_do  = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    chk("t1_req_drop", 32'(mem_req), 32'h0);
    chk("t1_cpu_dout", 32'(cpu_dout), 32'hBEEF);
    chk("t1_cpu_rdy", 32'(cpu_rdy), 32'h1);
    tick();
    chk("t1_rdy_hold", 32'(cpu_rdy), 32'h1);
    chk("t1_no_regrant", 32'(mem_req), 32'h0);
    cpu_act = 1'b0;
    tick();
    chk("t1_rdy_clear", 32'(cpu_rdy), 32'h0);
    chk("t1_dout_hold", 32'(cpu_dout), 32'hBEEF);

    // 2: PI write
    pi_req  = 1'b1;
    pi_we   = 1'b1;
    pi_addr = 23'h7FFFFF;
    pi_wdat = 16'h55AA;
    tick();
    chk("t2_mem_req", 32'(mem_req), 32'h1);
    chk("t2_mem_we", 32'(mem_we), 32'h1);
    chk("t2_mem_addr", 32'(mem_addr), 32'h7FFFFF);
    chk("t2_mem_di", 32'(mem_di), 32'h55AA);
    chk("t2_no_ack_yet", 32'(pi_ack), 32'h0);
    mem_ack = 1'b1;
    mem_do  = 16'h1111;
    tick();
    mem_ack = 1'b0;
    chk("t2_pi_ack", 32'(pi_ack), 32'h1);
    chk("t2_pi_rdat_kept", 32'(pi_rdat), 32'h0);
    chk("t2_req_drop", 32'(mem_req), 32'h0);
    tick();
    chk("t2_ack_single", 32'(pi_ack), 32'h0);
    chk("t2_no_regrant", 32'(mem_req), 32'h0);
    pi_req = 1'b0;

    // 3: simultaneous CPU edge and PI read, counter below max
    pi_we    = 1'b0;
    pi_addr  = 23'h000100;
    pi_req   = 1'b1;
    cpu_act  = 1'b1;
    cpu_addr = 23'h002000;
    tick();
    chk("t3_cpu_first", 32'({mem_req, mem_addr}), 32'({1'b1, 23'h002000}));
    chk("t3_cpu_we", 32'(mem_we), 32'h0);
    mem_ack = 1'b1;
    mem_do  = 16'hCAFE;
    tick();
    mem_ack = 1'b0;
    chk("t3_cpu_dout", 32'(cpu_dout), 32'hCAFE);
    chk("t3_cpu_rdy", 32'(cpu_rdy), 32'h1);
    chk("t3_req_drop", 32'(mem_req), 32'h0);
    tick();
    chk("t3_pi_grant", 32'({mem_req, mem_addr}), 32'({1'b1, 23'h000100}));
    chk("t3_pi_we", 32'(mem_we), 32'h0);
    cpu_act = 1'b0;
    mem_ack = 1'b1;
    mem_do  = 16'h1357;
    tick();
    mem_ack = 1'b0;
    chk("t3_pi_ack", 32'(pi_ack), 32'h1);
    chk("t3_pi_rdat", 32'(pi_rdat), 32'h1357);
    chk("t3_rdy_clear", 32'(cpu_rdy), 32'h0);
    tick();
    chk("t3_ack_single", 32'({pi_ack, mem_req}), 32'h0);
    pi_req = 1'b0;

    // 4: starvation guard under continuous CPU traffic (fresh counter)
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    pi_req   = 1'b1;
    pi_we    = 1'b0;
    pi_addr  = 23'h000ABC;
    cpu_act  = 1'b1;
    cpu_addr = 23'h010000;
    // Strobe re-asserted while each access is in flight, so a CPU request
    // is always pending when the arbiter returns to IDLE.
    for (int i = 0; i < 22; i++) begin
      tick();
      chk("t4_cpu_grant", 32'({mem_req, mem_addr}), 32'({1'b1, 23'h010000 + 23'(i)}));
      cpu_act = 1'b0;
      tick();
      cpu_act  = 1'b1;
      cpu_addr = 23'h010000 + 23'(i + 1);
      mem_ack  = 1'b1;
      mem_do   = 16'(i);
      tick();
      mem_ack  = 1'b0;
    end
    chk("t4_cpu_pending", 32'(dut.cpu_pend_q), 32'h1);
    tick();
    chk("t4_pi_wins", 32'({mem_req, mem_addr}), 32'({1'b1, 23'h000ABC}));
    chk("t4_cnt_cleared", 32'(dut.u_starve.cnt_q), 32'h0);
    mem_ack = 1'b1;
    mem_do  = 16'h4444;
    tick();
    mem_ack = 1'b0;
    chk("t4_pi_ack", 32'(pi_ack), 32'h1);
    chk("t4_pi_rdat", 32'(pi_rdat), 32'h4444);
    tick();
    chk("t4_cpu_after_pi", 32'({mem_req, mem_addr}), 32'({1'b1, 23'h010016}));
    pi_req  = 1'b0;
    mem_ack = 1'b1;
    mem_do  = 16'h9999;
    tick();
    mem_ack = 1'b0;
    chk("t4_cpu_dout", 32'(cpu_dout), 32'h9999);

    // 5: cpu_act falls while the CPU access is in flight
    cpu_act = 1'b0;
    tick();
    chk("t5_rdy_clear", 32'(cpu_rdy), 32'h0);
    cpu_act  = 1'b1;
    cpu_addr = 23'h000040;
    tick();
    chk("t5_grant", 32'({mem_req, mem_addr}), 32'({1'b1, 23'h000040}));
    cpu_act = 1'b0;
    tick();
    chk("t5_req_held1", 32'(mem_req), 32'h1);
    tick();
    chk("t5_req_held2", 32'({mem_req, mem_addr}), 32'({1'b1, 23'h000040}));
    mem_ack = 1'b1;
    mem_do  = 16'hDEAD;
    tick();
    mem_ack = 1'b0;
    chk("t5_req_drop", 32'(mem_req), 32'h0);
    chk("t5_rdy_low", 32'(cpu_rdy), 32'h0);
    chk("t5_dout_kept", 32'(cpu_dout), 32'h9999);
    tick();
    chk("t5_idle", 32'(dut.state_q), 32'(ST_IDLE));

    // 6: reset asserted during PI_BUSY
    pi_req  = 1'b1;
    pi_we   = 1'b1;
    pi_addr = 23'h000123;
    pi_wdat = 16'h0F0F;
    tick();
    chk("t6_pi_grant", 32'({mem_req, mem_we}), 32'h3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req", 32'(mem_req), 32'h0);
    chk("t6_rst_ack", 32'(pi_ack), 32'h0);
    pi_req = 1'b0;
    tick();
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    mem_do  = 16'h2222;
    tick();
    mem_ack = 1'b0;
    chk("t6_late_ack", 32'({pi_ack, mem_req}), 32'h0);
    chk("t6_state", 32'(dut.state_q), 32'(ST_IDLE));
    chk("t6_pi_rdat", 32'(pi_rdat), 32'h0);
    tick();
    chk("t6_still_quiet", 32'({pi_ack, mem_req}), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
